// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and constants for the A2D round scheduler.
package a2d_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    ERR   = 2'd3
  } sched_state_t;

  // Channel rotation used by the A2D interface
  localparam logic [1:0] CH_LFT  = 2'd0;
  localparam logic [1:0] CH_RGHT = 2'd1;
  localparam logic [1:0] CH_BATT = 2'd2;

  // Next channel in the lft -> rght -> batt -> lft rotation; 3 folds back to lft
  function automatic logic [1:0] ch_next(input logic [1:0] ch);
    logic [1:0] nxt_ch;
    case (ch)
      CH_LFT:  nxt_ch = CH_RGHT;
      CH_RGHT: nxt_ch = CH_BATT;
      CH_BATT: nxt_ch = CH_LFT;
      default: nxt_ch = CH_LFT;
    endcase
    return nxt_ch;
  endfunction

endpackage

// File: rtl/a2d_watchdog.sv
// a2d_watchdog: saturating up-counter with synchronous clear and a
// terminal-count flag. Used both as the request interval timer and as the
// SPI round watchdog.
module a2d_watchdog #(
  parameter int unsigned   W  = 12,
  parameter logic [W-1:0]  TC = {W{1'b1}}
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  // Count while enabled, stop at the terminal value; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en && (r_cnt != TC)) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/a2d_sched.sv
// a2d_sched: issues a one-cycle nxt request to the A2D interface every
// PERIOD clocks, follows its lft/rght/batt rotation, and strobes the
// matching result-valid one clock after the second SS_n rise of a round.
// A watchdog flags rounds that do not finish within TIMEOUT clocks.
// Optional build macro A2D_SCHED_BATT_LOW_EN adds a battery-low detector.
module a2d_sched
  import a2d_pkg::*;
#(
  parameter int unsigned           PERIOD_W = 17,
  parameter int unsigned           TOUT_W   = 12,
  parameter logic [PERIOD_W-1:0]   PERIOD   = 17'd100000,
  parameter logic [TOUT_W-1:0]     TIMEOUT  = 12'd4000
`ifdef A2D_SCHED_BATT_LOW_EN
  ,
  parameter logic [11:0]           BATT_THRESH = 12'h800
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        a2d_SS_n,
  input  logic        err_clr,
`ifdef A2D_SCHED_BATT_LOW_EN
  input  logic [11:0] batt,
  output logic        batt_low,
`endif
  output logic        nxt,
  output logic        lft_vld,
  output logic        rght_vld,
  output logic        batt_vld,
  output logic        busy,
  output logic        a2d_err
);

  localparam logic [PERIOD_W-1:0] TMR_TC  = PERIOD  - {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [TOUT_W-1:0]   TOUT_TC = TIMEOUT - {{(TOUT_W-1){1'b0}}, 1'b1};

  sched_state_t r_state;
  logic [1:0]   r_ch;
  logic [1:0]   r_ss_cnt;
  logic         r_ss_n_ff;
  logic         r_first;
  logic         r_nxt;
  logic         r_busy;
  logic         r_lft_vld;
  logic         r_rght_vld;
  logic         r_batt_vld;
  logic         r_err;

  logic         w_ss_rise;
  logic         w_issue;
  logic         w_done;
  logic         w_tout_hit;
  logic         w_tmr_tc;
  logic         w_tout_tc;
  logic         w_in_round;

  assign w_ss_rise  = a2d_SS_n & ~r_ss_n_ff;
  assign w_in_round = (r_state == ISSUE) || (r_state == XFER);
  // The very first request goes out immediately; later ones wait for the timer
  assign w_issue    = (r_state == IDLE) && en && (r_first || w_tmr_tc);
  assign w_done     = (r_state == XFER) && w_ss_rise && (r_ss_cnt == 2'd1);
  // A completing round beats a simultaneous timeout
  assign w_tout_hit = (r_state == XFER) && w_tout_tc && !w_done;

  // Interval timer: zero in the nxt cycle, frozen while scheduling is disabled
  a2d_watchdog #(
    .W  (PERIOD_W),
    .TC (TMR_TC)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_issue),
    .i_en  (en),
    .o_tc  (w_tmr_tc)
  );

  // Round watchdog: counts from the nxt cycle through the transfer
  a2d_watchdog #(
    .W  (TOUT_W),
    .TC (TOUT_TC)
  ) u_tout (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_issue),
    .i_en  (w_in_round),
    .o_tc  (w_tout_tc)
  );

  // Delayed copy of SS_n for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n_ff <= 1'b1;
    end else begin
      r_ss_n_ff <= a2d_SS_n;
    end
  end

  // Scheduler FSM with registered request, busy, strobe and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ch       <= CH_LFT;
      r_ss_cnt   <= 2'd0;
      r_first    <= 1'b1;
      r_nxt      <= 1'b0;
      r_busy     <= 1'b0;
      r_lft_vld  <= 1'b0;
      r_rght_vld <= 1'b0;
      r_batt_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_nxt      <= 1'b0;
      r_lft_vld  <= 1'b0;
      r_rght_vld <= 1'b0;
      r_batt_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state <= ISSUE;
            r_nxt   <= 1'b1;
            r_busy  <= 1'b1;
            r_first <= 1'b0;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ISSUE: begin
          r_state  <= XFER;
          r_busy   <= 1'b1;
          r_ss_cnt <= 2'd0;
        end
        XFER: begin
          if (w_done) begin
            // Strobe the channel that just finished, then move on
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_ch       <= ch_next(r_ch);
            r_lft_vld  <= (r_ch == CH_LFT);
            r_rght_vld <= (r_ch == CH_RGHT);
            r_batt_vld <= (r_ch == CH_BATT);
          end else if (w_tout_hit) begin
            // Channel index is kept; only a reset re-aligns with the interface
            r_state <= ERR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_busy <= 1'b1;
            if (w_ss_rise) begin
              r_ss_cnt <= r_ss_cnt + 2'd1;
            end else begin
              r_ss_cnt <= r_ss_cnt;
            end
          end
        end
        ERR: begin
          r_busy <= 1'b0;
          if (err_clr) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
          end else begin
            r_err   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign nxt      = r_nxt;
  assign busy     = r_busy;
  assign lft_vld  = r_lft_vld;
  assign rght_vld = r_rght_vld;
  assign batt_vld = r_batt_vld;
  assign a2d_err  = r_err;

`ifdef A2D_SCHED_BATT_LOW_EN
  logic [1:0] r_low_cnt;
  logic       r_batt_low;

  // Battery-low: three consecutive low samples set it, any good sample clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low_cnt  <= 2'd0;
      r_batt_low <= 1'b0;
    end else if (r_batt_vld) begin
      if (batt < BATT_THRESH) begin
        if (r_low_cnt != 2'd3) begin
          r_low_cnt <= r_low_cnt + 2'd1;
        end else begin
          r_low_cnt <= r_low_cnt;
        end
        if (r_low_cnt >= 2'd2) begin
          r_batt_low <= 1'b1;
        end else begin
          r_batt_low <= r_batt_low;
        end
      end else begin
        r_low_cnt  <= 2'd0;
        r_batt_low <= 1'b0;
      end
    end else begin
      r_low_cnt  <= r_low_cnt;
      r_batt_low <= r_batt_low;
    end
  end

  assign batt_low = r_batt_low;
`endif

endmodule
